// File: rtl/uart_boot_loader.sv
// uart_boot_loader: hunts a UART byte stream for the start marker 5a a5 0f f0,
// then packs the following bytes little-endian into 32-bit words. Each word is
// written to consecutive instruction-memory addresses until the word-aligned
// end marker 32'h5aa5_0ff0 arrives. The core is held in reset while loading.
// Optional feature macro: BOOT_TIMEOUT_EN enables an inter-byte idle timeout in LOAD.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam logic [31:0] START_MARK = 32'h5aa5_0ff0;
  localparam logic [31:0] END_MARK   = 32'h5aa5_0ff0;

  typedef enum logic {HUNT, LOAD} state_t;

  state_t      state, next_state;
  logic [31:0] history;
  logic [23:0] word_buf;
  logic [1:0]  byte_idx;
  logic        start_hit;
  logic        word_done;
  logic        end_hit;
  logic        has_room;
  logic        timeout_hit;
  logic [31:0] assembled;

  // The start marker is checked against the history plus the byte arriving now,
  // so the match is seen on the edge that samples the final marker byte.
  assign start_hit = (state == HUNT) && rx_valid && ({history[23:0], rx_data} == START_MARK);
  assign assembled = {rx_data, word_buf};
  assign word_done = (state == LOAD) && rx_valid && (byte_idx == 2'd3);
  assign end_hit   = word_done && (assembled == END_MARK);
  assign has_room  = {16'd0, word_count} < 32'(MAX_WORDS);

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Idle counter runs only in LOAD and restarts on every received byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idle_cnt <= '0;
    else if (state != LOAD || rx_valid)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end

  assign timeout_hit = (state == LOAD) && !rx_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES < 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= HUNT;
    else
      state <= next_state;
  end

  // Next-state decode: enter LOAD on the start marker, leave on end marker or timeout.
  always_comb begin
    next_state = state;
    case (state)
      HUNT: if (start_hit) next_state = LOAD;
      LOAD: if (end_hit || timeout_hit) next_state = HUNT;
      default: next_state = HUNT;
    endcase
  end

  // Datapath: marker history, word assembly, memory write strobe and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history           <= '0;
      word_buf          <= '0;
      byte_idx          <= '0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      core_hold         <= 1'b0;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      word_count        <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      load_done        <= 1'b0;
      if (state == HUNT) begin
        if (start_hit) begin
          history    <= '0;
          core_hold  <= 1'b1;
          word_count <= '0;
          load_error <= 1'b0;
          byte_idx   <= '0;
        end else if (rx_valid) begin
          history <= {history[23:0], rx_data};
        end
      end else if (timeout_hit) begin
        load_error <= 1'b1;
        core_hold  <= 1'b0;
        byte_idx   <= '0;
        history    <= '0;
      end else if (rx_valid) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= rx_data;
          2'd1:    word_buf[15:8]  <= rx_data;
          2'd2:    word_buf[23:16] <= rx_data;
          default: word_buf        <= word_buf;
        endcase
        if (end_hit) begin
          load_done <= 1'b1;
          core_hold <= 1'b0;
          history   <= '0;
        end else if (word_done && has_room) begin
          mem_write_enable  <= 1'b1;
          mem_write_address <= BASE_ADDR + {14'd0, word_count, 2'b00};
          mem_write_data    <= assembled;
          word_count        <= word_count + 16'd1;
        end else if (word_done) begin
          load_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed self-checking bench for uart_boot_loader.
// A second instance with MAX_WORDS=2 and TIMEOUT_CYCLES=100 covers overflow
// and, when BOOT_TIMEOUT_EN is defined, the idle timeout.
module tb_uart_boot_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        mem_write_enable, small_write_enable;
  logic [31:0] mem_write_address, small_write_address;
  logic [31:0] mem_write_data, small_write_data;
  logic        core_hold, small_core_hold;
  logic        load_done, small_load_done;
  logic        load_error, small_load_error;
  logic [15:0] word_count, small_word_count;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_count;
  logic [31:0] small_addr[$];
  logic [31:0] small_data[$];
  int          small_done_count;

  logic [7:0]  stream[$];

  uart_boot_loader dut (
    .clk               (clk),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .core_hold         (core_hold),
    .load_done         (load_done),
    .load_error        (load_error),
    .word_count        (word_count)
  );

  uart_boot_loader #(.MAX_WORDS(2), .TIMEOUT_CYCLES(100)) dut_small (
    .clk               (clk),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .mem_write_enable  (small_write_enable),
    .mem_write_address (small_write_address),
    .mem_write_data    (small_write_data),
    .core_hold         (small_core_hold),
    .load_done         (small_load_done),
    .load_error        (small_load_error),
    .word_count        (small_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe and done pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      wr_addr.push_back(mem_write_address);
      wr_data.push_back(mem_write_data);
    end
    if (load_done) done_count++;
    if (small_write_enable) begin
      small_addr.push_back(small_write_address);
      small_data.push_back(small_write_data);
    end
    if (small_load_done) small_done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    else
      pass_count++;
  endtask

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hdead_beef;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic sendStream(input logic [7:0] s[$]);
    foreach (s[i]) applyStimulus(s[i]);
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
    small_addr.delete();
    small_data.delete();
    done_count       = 0;
    small_done_count = 0;
  endtask

  task automatic doReset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clearLog();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    done_count       = 0;
    small_done_count = 0;
    @(negedge clk);
    #1;
    checkOutput("rst_we",    32'(mem_write_enable), 32'd0);
    checkOutput("rst_addr",  mem_write_address, 32'd0);
    checkOutput("rst_data",  mem_write_data, 32'd0);
    checkOutput("rst_hold",  32'(core_hold), 32'd0);
    checkOutput("rst_done",  32'(load_done), 32'd0);
    checkOutput("rst_err",   32'(load_error), 32'd0);
    checkOutput("rst_count", 32'(word_count), 32'd0);
    doReset();

    // Basic two-word load with hold timing.
    stream = {8'h5a, 8'ha5, 8'h0f};
    sendStream(stream);
    checkOutput("t1_hold_pre", 32'(core_hold), 32'd0);
    applyStimulus(8'hf0);
    checkOutput("t1_hold_on", 32'(core_hold), 32'd1);
    stream = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    sendStream(stream);
    checkOutput("t1_we",    32'(mem_write_enable), 32'd1);
    checkOutput("t1_wdata", mem_write_data, 32'h8070_6050);
    checkOutput("t1_count", 32'(word_count), 32'd2);
    stream = {8'hf0, 8'h0f, 8'ha5};
    sendStream(stream);
    checkOutput("t1_hold_mid", 32'(core_hold), 32'd1);
    applyStimulus(8'h5a);
    checkOutput("t1_hold_off", 32'(core_hold), 32'd0);
    checkOutput("t1_done",     32'(load_done), 32'd1);
    checkOutput("t1_no_we",    32'(mem_write_enable), 32'd0);
    @(negedge clk);
    checkOutput("t1_done_pulse", 32'(load_done), 32'd0);
    checkOutput("t1_nwr",   32'(wr_addr.size()), 32'd2);
    checkOutput("t1_a0",    qAt(wr_addr, 0), 32'd0);
    checkOutput("t1_d0",    qAt(wr_data, 0), 32'h4030_2010);
    checkOutput("t1_a1",    qAt(wr_addr, 1), 32'd4);
    checkOutput("t1_d1",    qAt(wr_data, 1), 32'h8070_6050);
    checkOutput("t1_ndone", 32'(done_count), 32'd1);

    // Noise prefix with overlapping partial match.
    clearLog();
    stream = {8'h00, 8'h5a, 8'h5a, 8'ha5, 8'h0f, 8'hf0, 8'h11, 8'h22, 8'h33, 8'h44,
              8'hf0, 8'h0f, 8'ha5, 8'h5a};
    sendStream(stream);
    @(negedge clk);
    checkOutput("t2_nwr",   32'(wr_addr.size()), 32'd1);
    checkOutput("t2_a0",    qAt(wr_addr, 0), 32'd0);
    checkOutput("t2_d0",    qAt(wr_data, 0), 32'h4433_2211);
    checkOutput("t2_count", 32'(word_count), 32'd1);
    checkOutput("t2_ndone", 32'(done_count), 32'd1);

    // End-marker bytes straddling a word boundary are plain data.
    clearLog();
    stream = {8'h5a, 8'ha5, 8'h0f, 8'hf0, 8'haa, 8'hbb, 8'hf0, 8'h0f, 8'ha5, 8'h5a,
              8'hcc, 8'hdd};
    sendStream(stream);
    checkOutput("t3_hold", 32'(core_hold), 32'd1);
    stream = {8'hf0, 8'h0f, 8'ha5, 8'h5a};
    sendStream(stream);
    @(negedge clk);
    checkOutput("t3_nwr",   32'(wr_addr.size()), 32'd2);
    checkOutput("t3_d0",    qAt(wr_data, 0), 32'h0ff0_bbaa);
    checkOutput("t3_d1",    qAt(wr_data, 1), 32'hddcc_5aa5);
    checkOutput("t3_a1",    qAt(wr_addr, 1), 32'd4);
    checkOutput("t3_ndone", 32'(done_count), 32'd1);

    // Overflow on the two-word instance.
    doReset();
    stream = {8'h5a, 8'ha5, 8'h0f, 8'hf0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c};
    sendStream(stream);
    checkOutput("t4_err_set", 32'(small_load_error), 32'd1);
    checkOutput("t4_hold",    32'(small_core_hold), 32'd1);
    stream = {8'hf0, 8'h0f, 8'ha5, 8'h5a};
    sendStream(stream);
    @(negedge clk);
    checkOutput("t4_nwr",     32'(small_addr.size()), 32'd2);
    checkOutput("t4_d1",      qAt(small_data, 1), 32'h0807_0605);
    checkOutput("t4_count",   32'(small_word_count), 32'd2);
    checkOutput("t4_err",     32'(small_load_error), 32'd1);
    checkOutput("t4_ndone",   32'(small_done_count), 32'd1);
    checkOutput("t4_big_cnt", 32'(word_count), 32'd3);
    checkOutput("t4_big_err", 32'(load_error), 32'd0);

    // Reset in the middle of a load.
    clearLog();
    stream = {8'h5a, 8'ha5, 8'h0f, 8'hf0, 8'hee, 8'hdd};
    sendStream(stream);
    reset = 1'b0;
    #1;
    checkOutput("t5_hold",  32'(core_hold), 32'd0);
    checkOutput("t5_we",    32'(mem_write_enable), 32'd0);
    checkOutput("t5_addr",  mem_write_address, 32'd0);
    checkOutput("t5_data",  mem_write_data, 32'd0);
    checkOutput("t5_count", 32'(word_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_nwr0", 32'(wr_addr.size()), 32'd0);
    stream = {8'h5a, 8'ha5, 8'h0f, 8'hf0, 8'h11, 8'h22, 8'h33, 8'h44,
              8'hf0, 8'h0f, 8'ha5, 8'h5a};
    sendStream(stream);
    @(negedge clk);
    checkOutput("t5_nwr",   32'(wr_addr.size()), 32'd1);
    checkOutput("t5_a0",    qAt(wr_addr, 0), 32'd0);
    checkOutput("t5_d0",    qAt(wr_data, 0), 32'h4433_2211);
    checkOutput("t5_ndone", 32'(done_count), 32'd1);

`ifdef BOOT_TIMEOUT_EN
    // Idle timeout on the instance with TIMEOUT_CYCLES=100.
    doReset();
    stream = {8'h5a, 8'ha5, 8'h0f, 8'hf0, 8'h77};
    sendStream(stream);
    repeat (105) @(negedge clk);
    checkOutput("t6_err",   32'(small_load_error), 32'd1);
    checkOutput("t6_hold",  32'(small_core_hold), 32'd0);
    checkOutput("t6_ndone", 32'(small_done_count), 32'd0);
    stream = {8'h5a, 8'ha5, 8'h0f, 8'hf0};
    sendStream(stream);
    checkOutput("t6_rehunt", 32'(small_core_hold), 32'd1);
    checkOutput("t6_errclr", 32'(small_load_error), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Byte-stream boot controller between the SoC UART receiver and the instruction memory write port. It hunts for a start marker in the received byte stream and assembles the following bytes into 32-bit little-endian words. It writes each word to consecutive instruction-memory addresses and stops at a word-aligned end marker. While loading, it holds the core in reset so that program download and execution never overlap.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, instruction-memory byte address of the first loaded word
- MAX_WORDS, 1024, instruction-memory capacity in words; writes beyond it are dropped
- TIMEOUT_CYCLES, 500000, inter-byte idle limit in LOAD (used only with BOOT_TIMEOUT_EN)

Ports:
- clk  input  1  system clock; all logic is rising-edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- rx_valid  input  1  one-cycle strobe from the UART receiver: rx_data holds a new byte
- rx_data  input  8  received byte
- mem_write_enable  output  1  one-cycle instruction-memory write strobe
- mem_write_address  output  32  byte address, BASE_ADDR + 4*index
- mem_write_data  output  32  assembled word
- core_hold  output  1  holds the core in reset while high
- load_done  output  1  one-cycle pulse on a good end marker
- load_error  output  1  sticky overflow or timeout flag; cleared by the next start marker
- word_count  output  16  words written in the current or last load

## Operation
- Reset values: every output is 0, the state is HUNT, and the byte shift register and byte index are cleared.
- HUNT:
  - Every rx_valid shifts rx_data into a 4-byte history.
  - The history matching 5a,a5,0f,f0 (oldest first) causes the transition to LOAD.
  - On that transition: core_hold=1, word_count=0, load_error=0, byte index=0.
  - Overlapping partial matches are honoured. Example: 5a 5a a5 0f f0 matches.
- LOAD:
  - rx_valid bytes fill the word little-endian. Byte index 0 goes to bits [7:0] and index 3 to bits [31:24].
  - After the 4th byte, the assembled word is checked.
  - A word equal to 32'h5aa5_0ff0 (bytes f0,0f,a5,5a) is the end marker. The block does not write it, pulses load_done, drops core_hold and returns to HUNT.
  - Any other word is written when word_count < MAX_WORDS: mem_write_enable pulses with address BASE_ADDR + 4*word_count, then word_count increments.
  - Any other word with word_count == MAX_WORDS is dropped and load_error is set. Loading continues, so the end marker is still detected.
- The end marker is recognised only on word boundaries. f0 0f a5 5a straddling two words is data.
- A start marker seen while in LOAD is data; there is no restart.
- The history register is cleared when LOAD is entered and when it is left.

## Timing
- mem_write_enable, address and data are registered. They are valid for exactly one cycle, the cycle after the clock edge that samples the 4th rx_valid byte.
- core_hold:
  - Rises on the cycle after the edge that samples the final start-marker byte.
  - Falls on the cycle after the edge that samples the final end-marker byte, the same cycle load_done is high.
- word_count updates in the same cycle as mem_write_enable.
- rx_valid may arrive on back-to-back cycles. The block sustains one byte per clock and never stalls, so there is no ready signal.
- rx_valid while a write strobe is in progress is accepted normally. The word register is double-buffered, so the strobed data is stable.
- Asserting reset mid-load aborts immediately: outputs go to their reset values, including core_hold=0, and no partial word is written.
- A byte arriving on the same edge as the state change is consumed by the new state's logic only from the next edge. The final marker byte is never reused.

## Configuration
- BOOT_TIMEOUT_EN defined:
  - In LOAD, a counter clears on every rx_valid and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES, the block sets load_error, drops core_hold, returns to HUNT and does not pulse load_done.
  - A partial word is discarded.
- BOOT_TIMEOUT_EN undefined: no counter exists. LOAD persists until the end marker or reset, and load_error is set only by overflow.

## Test plan
- Stream 5a a5 0f f0 10 20 30 40 50 60 70 80 f0 0f a5 5a: expect writes 32'h4030_2010 @0 and 32'h8070_6050 @4; load_done once; word_count=2; core_hold high from after the 4th byte to after the 16th byte.
- Noise 00 5a 5a a5 0f f0, then one word 11 22 33 44 and the end marker: the start marker is found despite the prefix; one write of 32'h4433_2211.
- Data word f0 0f a5 5a offset by two bytes (aa bb f0 0f a5 5a cc dd, then the end marker): writes 32'h0ff0_bbaa and 32'hddcc_5aa5, then load_done.
- MAX_WORDS=2, three data words plus the end marker: exactly two writes, load_error=1, load_done still pulses, word_count=2.
- Reset (reset=0) after the start marker plus two data bytes: core_hold=0, all outputs 0, no write. A later full frame loads correctly from BASE_ADDR.
- With BOOT_TIMEOUT_EN and TIMEOUT_CYCLES=100: start marker, 1 byte, then idle for 100 cycles. Expect load_error=1, core_hold=0, no load_done, state HUNT.
